// File: rtl/fetch_queue.sv
// fetch_queue: variable-latency instruction fetch front end with a DEPTH-entry {pc, inst} queue; FETCH_PERF_EN adds perf counters.
// Latency: one request in flight; a response is visible on inst_valid the cycle after imem_rvalid.
// Backpressure: no request is issued while the queue is full; decode drains it through inst_valid/inst_ready.

// fq_fifo: generic flushable FIFO with a zero-latency head view and occupancy count.
// Latency: a pushed word is at the head the cycle after the push when the FIFO was empty.
// Backpressure: none internally; the caller must only push when count < DEPTH.
module fq_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push_vld,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop_rdy,
   output logic                   head_vld,
   output logic [W-1:0]           head_dat,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          pop;

   assign head_vld = (count != '0);
   assign pop      = pop_rdy && head_vld;
   // Empty head reads as zero so inst/inst_pc idle at 0.
   assign head_dat = head_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + AW'(1);
         if (pop)      rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_vld) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld && !flush) mem[wr_ptr] <= push_dat;
   end
endmodule

// fetch_queue: issues word fetches over req/gnt/rvalid and queues {pc, inst} for decode; redirect flushes.
// Latency: grant to next request is 2 cycles minimum; entry visible the cycle after imem_rvalid.
// Backpressure: imem_req drops while the queue is full; decode holds inst/inst_pc stable by deasserting inst_ready.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [15:0] perf_dropped,
`endif
   input  logic        inst_ready
);
   localparam int            CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } fq_entry_t;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_DROP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   fpc;
   logic [31:0]   fpc_nxt;
   logic [31:0]   req_pc;
   logic [CW-1:0] count;
   logic          grant;
   logic          push_vld;
   logic          pop_rdy;
   fq_entry_t     push_dat;
   fq_entry_t     head_dat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_REQ;
         fpc    <= RESET_PC;
         req_pc <= '0;
      end else begin
         state <= state_nxt;
         fpc   <= fpc_nxt;
         if (grant) req_pc <= fpc;
      end
   end

   always_comb begin
      state_nxt = state;
      fpc_nxt   = fpc;
      grant     = 1'b0;
      push_vld  = 1'b0;
      imem_req  = (state == ST_REQ) && (count < FULL);
      case (state)
         ST_REQ: begin
            // A grant alongside redirect still leaves a response in flight, which must be dropped.
            if (imem_req && imem_gnt) begin
               grant     = 1'b1;
               state_nxt = redirect ? ST_DROP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               push_vld  = !redirect;
               state_nxt = ST_REQ;
            end else if (redirect) begin
               state_nxt = ST_DROP;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) state_nxt = ST_REQ;
         end
         default: state_nxt = ST_REQ;
      endcase
      if (redirect)   fpc_nxt = redirect_pc & 32'hFFFF_FFFC;
      else if (grant) fpc_nxt = fpc + 32'd4;
   end

   assign imem_addr = fpc;
   assign push_dat  = '{pc: req_pc, ins: imem_rdata};
   assign pop_rdy   = inst_valid && inst_ready && !redirect;

   fq_fifo #(
      .W     ($bits(fq_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_rdy  (pop_rdy),
      .head_vld (inst_valid),
      .head_dat (head_dat),
      .count    (count)
   );

   assign inst    = head_dat.ins;
   assign inst_pc = head_dat.pc;

`ifdef FETCH_PERF_EN
   logic [CW:0]  drop_inc;
   logic [16:0]  drop_sum;

   always_comb begin
      drop_inc = '0;
      if (redirect) drop_inc = {1'b0, count};
      // A response discarded either as stale or by a same-cycle redirect.
      if (imem_rvalid && ((state == ST_DROP) || (state == ST_WAIT && redirect)))
         drop_inc = drop_inc + (CW+1)'(1);
      drop_sum = {1'b0, perf_dropped} + 17'(drop_inc);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(pop_rdy);
         perf_dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
`else
   // Build without performance counters.
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: memory model pushes expected {pc, inst} per response, monitor checks pops.
`timescale 1ns/1ps
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [15:0] perf_dropped;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_3000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
`ifdef FETCH_PERF_EN
      .perf_fetched (perf_fetched),
      .perf_dropped (perf_dropped),
`endif
      .inst_ready  (inst_ready)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] gnt_log[$];

   // Memory model state
   int          lat = 1;
   int          cnt = 0;
   bit          gnt_en = 1'b0;
   bit          pend = 1'b0;
   bit          pend_stale = 1'b0;
   logic [31:0] mfpc = 32'h0000_3000;
   logic [31:0] pend_pc = '0;
   logic [31:0] pend_addr = '0;
   bit          p_gnt = 1'b0;
   bit          p_rv = 1'b0;
   bit          p_redir = 1'b0;
   logic [31:0] p_rpc = '0;
   logic [31:0] p_addr = '0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   function automatic logic [31:0] log_at(int i);
      if (i < gnt_log.size()) return gnt_log[i];
      return 'x;
   endfunction

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(string name);
      int i = 0;
      while (i < 200 && (pend || imem_rvalid || exp_q.size() != 0 || inst_valid)) begin
         step(1);
         i++;
      end
      check(name, 32'(i < 200), 32'd1);
   endtask

   // Memory: settles what the previous posedge consumed, then drives the next cycle's gnt/rvalid.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         pend = 0; pend_stale = 0; cnt = 0;
         p_gnt = 0; p_rv = 0; p_redir = 0;
         mfpc = 32'h0000_3000;
         imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      end else begin
         if (p_rv) begin
            if (!pend_stale && !p_redir)
               exp_q.push_back('{pc: pend_pc, ins: pend_addr ^ 32'h5A5A_A5A5});
            pend = 0;
         end
         if (p_redir) begin
            exp_q.delete();
            if (pend) pend_stale = 1;
         end
         if (p_gnt) begin
            pend = 1;
            pend_stale = p_redir;
            pend_pc = mfpc;
            pend_addr = p_addr;
            cnt = lat;
            gnt_log.push_back(p_addr);
         end
         if (p_redir)    mfpc = p_rpc & 32'hFFFF_FFFC;
         else if (p_gnt) mfpc = mfpc + 32'd4;

         imem_rvalid = 0;
         if (pend && !imem_rvalid) begin
            cnt--;
            if (cnt == 0) begin
               imem_rvalid = 1;
               imem_rdata = pend_addr ^ 32'h5A5A_A5A5;
            end
         end
         imem_gnt = gnt_en && imem_req && !pend;
         p_gnt = imem_gnt; p_rv = imem_rvalid; p_redir = redirect;
         p_rpc = redirect_pc; p_addr = imem_addr;
      end
   end

   // Monitor: every pop is compared against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst && inst_valid && inst_ready && !redirect) begin
         if (exp_q.size() == 0) begin
            check("pop_unexpected_pc", inst_pc, 32'hxxxx_xxxx);
         end else begin
            e = exp_q.pop_front();
            check("pop_pc", inst_pc, e.pc);
            check("pop_inst", inst, e.ins);
         end
      end
   end

   initial begin
      int i;
      step(2);
      check("rst_req", 32'(imem_req), 32'd1);
      check("rst_addr", imem_addr, 32'h0000_3000);
      check("rst_vld", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_pc", inst_pc, 32'd0);

      // Streaming with a 1-cycle memory
      rst = 1; inst_ready = 1; lat = 1; gnt_en = 1;
      step(12);
      gnt_en = 0;
      wait_idle("t1_idle");
      check("t1_addr0", log_at(0), 32'h0000_3000);
      check("t1_addr1", log_at(1), 32'h0000_3004);
      check("t1_addr2", log_at(2), 32'h0000_3008);

      // Fill to DEPTH with decode stalled, then a single pop
      gnt_log.delete(); inst_ready = 0; gnt_en = 1;
      step(20);
      check("t2_grants", 32'(gnt_log.size()), 32'd4);
      check("t2_req_full", 32'(imem_req), 32'd0);
      check("t2_vld", 32'(inst_valid), 32'd1);
      if (exp_q.size() > 0) check("t2_head_pc", inst_pc, exp_q[0].pc);
      inst_ready = 1;
      step(1);
      inst_ready = 0;
      check("t2_req_after_pop", 32'(imem_req), 32'd1);
      step(4);
      check("t2_refill", 32'(gnt_log.size()), 32'd5);
      gnt_en = 0; inst_ready = 1;
      wait_idle("t2_idle");

      // Redirect in WAIT; response arrives later and must be dropped
      lat = 5; gnt_en = 1;
      i = 0;
      while (i < 50 && !pend) begin step(1); i++; end
      check("t3_grant", 32'(pend), 32'd1);
      gnt_en = 0;
      redirect = 1; redirect_pc = 32'h0000_4007;
      step(1);
      redirect = 0;
      gnt_log.delete();
      check("t3_vld_after_redir", 32'(inst_valid), 32'd0);
      check("t3_req_drop", 32'(imem_req), 32'd0);
      i = 0;
      while (i < 50 && pend) begin step(1); i++; end
      check("t3_resp", 32'(pend), 32'd0);
      lat = 1; gnt_en = 1;
      step(4);
      gnt_en = 0;
      check("t3_addr", log_at(0), 32'h0000_4004);
      wait_idle("t3_idle");

      // Redirect coincident with rvalid in WAIT while 2 entries are queued
      inst_ready = 0; lat = 1; gnt_en = 1;
      i = 0;
      while (i < 100 && !(exp_q.size() == 2 && imem_gnt)) begin step(1); i++; end
      check("t4_setup", 32'(i < 100), 32'd1);
      check("t4_pre_vld", 32'(inst_valid), 32'd1);
      gnt_en = 0;
      redirect = 1; redirect_pc = 32'h0000_5000;
      step(1);
      redirect = 0;
      check("t4_empty", 32'(inst_valid), 32'd0);
      check("t4_req", 32'(imem_req), 32'd1);
      check("t4_addr", imem_addr, 32'h0000_5000);
      inst_ready = 1;
      wait_idle("t4_idle");

      // Address wrap at the top of memory
      redirect = 1; redirect_pc = 32'hFFFF_FFFE;
      step(1);
      redirect = 0;
      gnt_log.delete(); lat = 1; gnt_en = 1;
      step(5);
      gnt_en = 0;
      check("t5_addr0", log_at(0), 32'hFFFF_FFFC);
      check("t5_addr1", log_at(1), 32'h0000_0000);
      wait_idle("t5_idle");

      // Reset while entries are queued
      inst_ready = 0; lat = 1; gnt_en = 1;
      step(6);
      check("t6_pre_vld", 32'(inst_valid), 32'd1);
      rst = 0; gnt_en = 0;
      #1;
      check("mrst_req", 32'(imem_req), 32'd1);
      check("mrst_addr", imem_addr, 32'h0000_3000);
      check("mrst_vld", 32'(inst_valid), 32'd0);
      check("mrst_inst", inst, 32'd0);
`ifdef FETCH_PERF_EN
      check("mrst_perf_dropped", 32'(perf_dropped), 32'd0);
      check("mrst_perf_fetched", perf_fetched, 32'd0);
`endif
      step(2);

      // Flush 3 queued entries plus 1 stale response
      rst = 1; gnt_en = 1; lat = 1; inst_ready = 0;
      i = 0;
      while (i < 100 && exp_q.size() != 3) begin step(1); i++; end
      check("t6_fill", 32'(exp_q.size()), 32'd3);
      lat = 3; gnt_en = 0;
      step(1);
      check("t6_vld3", 32'(inst_valid), 32'd1);
      redirect = 1; redirect_pc = 32'h0000_6000;
      step(1);
      redirect = 0;
      check("t6_flushed", 32'(inst_valid), 32'd0);
      step(5);
`ifdef FETCH_PERF_EN
      check("t6_perf_dropped", 32'(perf_dropped), 32'd4);
`endif
      check("t6_addr", imem_addr, 32'h0000_6000);
      inst_ready = 1;
      wait_idle("t6_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
